// File: rtl/pixel_preprocess_pkg.sv
// pixel_preprocess_pkg
//
// Shared definitions for the pixel preprocessing pipeline: the processing
// mode encodings, the integer luma weights (they sum to 256 so the weighted
// sum divided by 256 can never exceed the channel range), the fixed pipeline
// latency and the identity channel permutation used after reset.
package pixel_preprocess_pkg;

    // Processing modes as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_PERMUTE  = 2'd0,
        MODE_GRAY     = 2'd1,
        MODE_BINARIZE = 2'd2,
        MODE_BYPASS   = 2'd3
    } mode_e;

    // Luma weights for ch2, ch1 and ch0 respectively.
    localparam int LUMA_W2 = 77;
    localparam int LUMA_W1 = 150;
    localparam int LUMA_W0 = 29;

    // Input-to-output latency in clock cycles, identical for every mode.
    localparam int LATENCY = 3;

    // Output channel k takes input channel k.
    localparam logic [5:0] PERM_IDENTITY = 6'b10_01_00;

endpackage

// File: rtl/pixel_preprocess_luma_calc.sv
// luma_calc
//
// Two-stage grayscale computation. The first register stage holds the three
// weighted channel products, the second holds the gray value, which is the
// sum of the products divided by 256.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset, clears both stages
//   pix   - pixel in, ch2 = [3D-1:2D], ch1 = [2D-1:D], ch0 = [D-1:0]
//   gray  - gray value, valid two cycles after pix
module luma_calc
    import pixel_preprocess_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*DATA_W-1:0]   pix,
    output logic [DATA_W-1:0]     gray
);

    localparam int PROD_W = DATA_W + 8;

    logic [PROD_W-1:0] prod2;
    logic [PROD_W-1:0] prod1;
    logic [PROD_W-1:0] prod0;
    logic [PROD_W-1:0] prod_sum;

    // Weighted products of each channel. Each weight fits in 8 bits, so a
    // product fits in DATA_W+8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod2 <= '0;
            prod1 <= '0;
            prod0 <= '0;
        end else begin
            prod2 <= PROD_W'(LUMA_W2) * PROD_W'(pix[3*DATA_W-1:2*DATA_W]);
            prod1 <= PROD_W'(LUMA_W1) * PROD_W'(pix[2*DATA_W-1:DATA_W]);
            prod0 <= PROD_W'(LUMA_W0) * PROD_W'(pix[DATA_W-1:0]);
        end
    end

    // The weights sum to 256, so the largest possible sum is
    // (2^DATA_W - 1) * 256, which still fits in DATA_W+8 bits.
    assign prod_sum = prod2 + prod1 + prod0;

    // Gray is the top DATA_W bits of the weighted sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray <= '0;
        end else begin
            gray <= DATA_W'(prod_sum >> 8);
        end
    end

endmodule

// File: rtl/pixel_preprocess.sv
// pixel_preprocess
//
// Three-stage video pixel pipeline. Stage 1 permutes the colour channels
// (or passes the pixel untouched in bypass), stages 2-3 compute a luma value
// in luma_calc, and the output is picked from the permuted pixel, the gray
// value replicated on all channels, or a binarized gray. Configuration is
// shadowed only at the rising edge of vsync_in so a frame is processed with
// a single configuration, and each pixel carries its own mode and threshold
// down the pipe.
//
// Ports:
//   clk, rst                      - clock and asynchronous active-high reset
//   video_in                      - input pixel, 3 channels of DATA_W bits
//   de_in, hsync_in, vsync_in     - timing strobes aligned to video_in
//   perm_sel                      - output channel k <- input channel
//                                   perm_sel[2k+1:2k]; code 3 gives zero
//   mode                          - 0 permute, 1 gray, 2 binarize, 3 bypass
//   threshold                     - binarize threshold
//   video_out                     - processed pixel, zero whenever de_out is 0
//   de_out, hsync_out, vsync_out  - strobes delayed to match video_out
module pixel_preprocess
    import pixel_preprocess_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PIX_W  = 3 * DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     video_in,
    input  logic                 de_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic [5:0]           perm_sel,
    input  logic [1:0]           mode,
    input  logic [DATA_W-1:0]    threshold,
    output logic [PIX_W-1:0]     video_out,
    output logic                 de_out,
    output logic                 hsync_out,
    output logic                 vsync_out
);

    localparam logic [DATA_W-1:0] THR_RESET = {1'b1, {(DATA_W-1){1'b0}}};

    // Active (shadowed) configuration.
    logic              vsync_prev;
    logic [5:0]        act_perm;
    mode_e             act_mode;
    logic [DATA_W-1:0] act_thr;

    // Pipeline registers.
    logic [PIX_W-1:0]  s1_pix, s2_pix, s3_pix;
    mode_e             s1_mode, s2_mode, s3_mode;
    logic [DATA_W-1:0] s1_thr, s2_thr, s3_thr;
    logic [2:0]        s1_strb, s2_strb, s3_strb;
    logic [DATA_W-1:0] s3_gray;
    logic [PIX_W-1:0]  perm_pix;

    // Selects one input channel by its 2-bit code; code 3 yields a zero channel.
    function automatic logic [DATA_W-1:0] pick_channel(
        input logic [PIX_W-1:0] pix,
        input logic [1:0]       code
    );
        case (code)
            2'd0:    pick_channel = pix[DATA_W-1:0];
            2'd1:    pick_channel = pix[2*DATA_W-1:DATA_W];
            2'd2:    pick_channel = pix[3*DATA_W-1:2*DATA_W];
            default: pick_channel = '0;
        endcase
    endfunction

    // Configuration shadow: new settings are taken only on a vsync rising
    // edge, so a change made mid-frame waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            act_perm   <= PERM_IDENTITY;
            act_mode   <= MODE_PERMUTE;
            act_thr    <= THR_RESET;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_in && !vsync_prev) begin
                act_perm <= perm_sel;
                act_mode <= mode_e'(mode);
                act_thr  <= threshold;
            end
        end
    end

    // Channel permutation of the incoming pixel using the active selection.
    always_comb begin
        perm_pix = '0;
        perm_pix[DATA_W-1:0]          = pick_channel(video_in, act_perm[1:0]);
        perm_pix[2*DATA_W-1:DATA_W]   = pick_channel(video_in, act_perm[3:2]);
        perm_pix[3*DATA_W-1:2*DATA_W] = pick_channel(video_in, act_perm[5:4]);
    end

    // Stage 1 captures the pixel together with the mode and threshold it
    // will be processed with; stages 2 and 3 just delay them alongside
    // luma_calc so everything meets at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_pix  <= '0;
            s1_mode <= MODE_PERMUTE;
            s1_thr  <= '0;
            s1_strb <= '0;
            s2_pix  <= '0;
            s2_mode <= MODE_PERMUTE;
            s2_thr  <= '0;
            s2_strb <= '0;
            s3_pix  <= '0;
            s3_mode <= MODE_PERMUTE;
            s3_thr  <= '0;
            s3_strb <= '0;
        end else begin
            s1_pix  <= (act_mode == MODE_BYPASS) ? video_in : perm_pix;
            s1_mode <= act_mode;
            s1_thr  <= act_thr;
            s1_strb <= {de_in, hsync_in, vsync_in};
            s2_pix  <= s1_pix;
            s2_mode <= s1_mode;
            s2_thr  <= s1_thr;
            s2_strb <= s1_strb;
            s3_pix  <= s2_pix;
            s3_mode <= s2_mode;
            s3_thr  <= s2_thr;
            s3_strb <= s2_strb;
        end
    end

    luma_calc #(
        .DATA_W (DATA_W)
    ) u_luma_calc (
        .clk  (clk),
        .rst  (rst),
        .pix  (s1_pix),
        .gray (s3_gray)
    );

    // Output selection from the stage-3 registers. Blanking cycles are
    // forced to zero regardless of mode.
    always_comb begin
        video_out = '0;
        if (s3_strb[2]) begin
            case (s3_mode)
                MODE_GRAY:     video_out = {s3_gray, s3_gray, s3_gray};
                MODE_BINARIZE: video_out = (s3_gray >= s3_thr) ? '1 : '0;
                default:       video_out = s3_pix;
            endcase
        end
    end

    assign de_out    = s3_strb[2];
    assign hsync_out = s3_strb[1];
    assign vsync_out = s3_strb[0];

endmodule

// File: tb/tb_pixel_preprocess.sv
// tb_pixel_preprocess
//
// Self-checking bench for pixel_preprocess (DATA_W = 8). A behavioural
// model computes each output pixel from the channel rules with plain integer
// arithmetic and places it in a queue that models the three-cycle delay.
module tb_pixel_preprocess;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] video_in = '0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [5:0]  perm_sel = 6'b10_01_00;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  threshold = 8'h80;
    logic [23:0] video_out;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    int checks = 0;
    int failures = 0;

    // Model state: configuration in force and the in-flight expectations,
    // each entry packed as {de, hsync, vsync, pixel}.
    logic [5:0]  m_perm;
    logic [1:0]  m_mode;
    logic [7:0]  m_thr;
    logic        m_prev_vs;
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    pixel_preprocess #(
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .video_in  (video_in),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .perm_sel  (perm_sel),
        .mode      (mode),
        .threshold (threshold),
        .video_out (video_out),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    // Expected output pixel for one input pixel under a given configuration.
    function automatic logic [23:0] model_pixel(
        input logic [23:0] pix,
        input logic        de,
        input logic [5:0]  p,
        input logic [1:0]  m,
        input logic [7:0]  thr
    );
        int ch[3];
        int o[3];
        int sel;
        int gray;
        int val;
        if (!de) return 24'h0;
        if (m == 2'd3) return pix;
        for (int i = 0; i < 3; i++) ch[i] = int'(pix >> (8 * i)) & 255;
        for (int k = 0; k < 3; k++) begin
            sel = int'(p >> (2 * k)) & 3;
            o[k] = (sel == 3) ? 0 : ch[sel];
        end
        val = o[2] * 65536 + o[1] * 256 + o[0];
        gray = (77 * o[2] + 150 * o[1] + 29 * o[0]) / 256;
        if (m == 2'd1) val = gray * 65793;
        else if (m == 2'd2) val = (gray >= int'(thr)) ? 24'hFFFFFF : 0;
        return 24'(val);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(27'h0);
        exp_q.push_back(27'h0);
        m_perm = 6'b10_01_00;
        m_mode = 2'd0;
        m_thr = 8'h80;
        m_prev_vs = 1'b0;
    endtask

    // Drives one cycle of input (called at posedge+1), advances the model
    // and returns the observed output and the model's output for this cycle.
    task automatic drive_cycle(
        input  logic [23:0] pix,
        input  logic        de,
        input  logic        hs,
        input  logic        vs,
        output logic [26:0] act,
        output logic [26:0] exp
    );
        video_in = pix;
        de_in = de;
        hsync_in = hs;
        vsync_in = vs;
        exp_q.push_back({de, hs, vs, model_pixel(pix, de, m_perm, m_mode, m_thr)});
        if (vs && !m_prev_vs) begin
            m_perm = perm_sel;
            m_mode = mode;
            m_thr = threshold;
        end
        m_prev_vs = vs;
        @(posedge clk);
        #1;
        act = {de_out, hsync_out, vsync_out, video_out};
        exp = exp_q.pop_front();
    endtask

    // Sends one pixel followed by two blank cycles; returns that pixel's output.
    task automatic flush_pixel(
        input  logic [23:0] pix,
        input  logic        de,
        input  logic        hs,
        output logic [26:0] act,
        output logic [26:0] exp
    );
        drive_cycle(pix, de, hs, 1'b0, act, exp);
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, act, exp);
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, act, exp);
    endtask

    // Presents a configuration and pulses vsync so it becomes active.
    task automatic load_cfg(input logic [5:0] p, input logic [1:0] m, input logic [7:0] t);
        logic [26:0] a, e;
        perm_sel = p;
        mode = m;
        threshold = t;
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b1, a, e);
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, a, e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({de_out, hsync_out, vsync_out, video_out} !== 27'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h",
                     {de_out, hsync_out, vsync_out, video_out}, 27'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_identity();
        logic [26:0] a, e;
        drive_cycle(24'h112233, 1'b1, 1'b1, 1'b1, a, e);
        checks++;
        if (a !== 27'h0) begin
            failures++;
            $display("[TB] FAIL latency_cycle1: got %h expected %h", a, 27'h0);
        end
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, a, e);
        checks++;
        if (a !== 27'h0) begin
            failures++;
            $display("[TB] FAIL latency_cycle2: got %h expected %h", a, 27'h0);
        end
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, a, e);
        checks++;
        if (a !== {3'b111, 24'h112233} || a !== e) begin
            failures++;
            $display("[TB] FAIL identity_cycle3: got %h expected %h", a, {3'b111, 24'h112233});
        end
    endtask

    task automatic test_perm();
        logic [26:0] a, e;
        load_cfg(6'b00_10_01, 2'd0, 8'h80);
        flush_pixel(24'hAABBCC, 1'b1, 1'b0, a, e);
        checks++;
        if (a[23:0] !== 24'hCCAABB || a !== e) begin
            failures++;
            $display("[TB] FAIL perm_rotate: got %h expected %h", a[23:0], 24'hCCAABB);
        end
        perm_sel = 6'b10_01_00;
        flush_pixel(24'hAABBCC, 1'b1, 1'b0, a, e);
        checks++;
        if (a[23:0] !== 24'hCCAABB || a !== e) begin
            failures++;
            $display("[TB] FAIL perm_midframe_hold: got %h expected %h", a[23:0], 24'hCCAABB);
        end
        load_cfg(6'b00_00_00, 2'd0, 8'h80);
        flush_pixel(24'hAABBCC, 1'b1, 1'b0, a, e);
        checks++;
        if (a[23:0] !== 24'hCCCCCC || a !== e) begin
            failures++;
            $display("[TB] FAIL perm_duplicate: got %h expected %h", a[23:0], 24'hCCCCCC);
        end
    endtask

    task automatic test_gray();
        logic [26:0] a, e;
        logic [23:0] pix_list[3] = '{24'hFFFFFF, 24'h000000, 24'hFF0000};
        logic [23:0] want_list[3] = '{24'hFFFFFF, 24'h000000, 24'h4C4C4C};
        load_cfg(6'b10_01_00, 2'd1, 8'h80);
        for (int i = 0; i < 3; i++) begin
            flush_pixel(pix_list[i], 1'b1, 1'b0, a, e);
            checks++;
            if (a[23:0] !== want_list[i] || a !== e) begin
                failures++;
                $display("[TB] FAIL gray_%0d: got %h expected %h", i, a[23:0], want_list[i]);
            end
        end
    endtask

    task automatic test_binarize();
        logic [26:0] a, e;
        load_cfg(6'b10_01_00, 2'd2, 8'h80);
        flush_pixel(24'h808080, 1'b1, 1'b0, a, e);
        checks++;
        if (a[23:0] !== 24'hFFFFFF || a !== e) begin
            failures++;
            $display("[TB] FAIL binarize_at_threshold: got %h expected %h", a[23:0], 24'hFFFFFF);
        end
        flush_pixel(24'h7F7F7F, 1'b1, 1'b0, a, e);
        checks++;
        if (a[23:0] !== 24'h000000 || a !== e) begin
            failures++;
            $display("[TB] FAIL binarize_below: got %h expected %h", a[23:0], 24'h000000);
        end
    endtask

    task automatic test_zero_cases();
        logic [26:0] a, e;
        load_cfg(6'b11_11_11, 2'd0, 8'h80);
        flush_pixel(24'h123456, 1'b1, 1'b0, a, e);
        checks++;
        if (a !== {3'b100, 24'h0} || a !== e) begin
            failures++;
            $display("[TB] FAIL perm_code3_zero: got %h expected %h", a, {3'b100, 24'h0});
        end
        load_cfg(6'b10_01_00, 2'd3, 8'h80);
        flush_pixel(24'hABCDEF, 1'b0, 1'b1, a, e);
        checks++;
        if (a !== {3'b010, 24'h0} || a !== e) begin
            failures++;
            $display("[TB] FAIL blank_forced_zero: got %h expected %h", a, {3'b010, 24'h0});
        end
        flush_pixel(24'hABCDEF, 1'b1, 1'b0, a, e);
        checks++;
        if (a[23:0] !== 24'hABCDEF || a !== e) begin
            failures++;
            $display("[TB] FAIL bypass: got %h expected %h", a[23:0], 24'hABCDEF);
        end
    endtask

    task automatic test_reset_mid_flight();
        logic [26:0] a, e;
        load_cfg(6'b10_01_00, 2'd1, 8'h80);
        perm_sel = 6'b00_10_01;
        mode = 2'd1;
        for (int i = 0; i < 3; i++) drive_cycle(24'h405060 + 24'(i), 1'b1, 1'b1, 1'b0, a, e);
        #3;
        rst = 1'b1;
        de_in = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        #1;
        checks++;
        if ({de_out, hsync_out, vsync_out, video_out} !== 27'h0) begin
            failures++;
            $display("[TB] FAIL reset_async_clear: got %h expected %h",
                     {de_out, hsync_out, vsync_out, video_out}, 27'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_cycle(24'h112233, 1'b1, 1'b0, 1'b0, a, e);
        checks++;
        if (a !== 27'h0) begin
            failures++;
            $display("[TB] FAIL no_stale_1: got %h expected %h", a, 27'h0);
        end
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, a, e);
        checks++;
        if (a !== 27'h0) begin
            failures++;
            $display("[TB] FAIL no_stale_2: got %h expected %h", a, 27'h0);
        end
        drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, a, e);
        checks++;
        if (a !== {3'b100, 24'h112233} || a !== e) begin
            failures++;
            $display("[TB] FAIL reset_config_identity: got %h expected %h", a, {3'b100, 24'h112233});
        end
    endtask

    task automatic test_random();
        logic [26:0] a, e;
        for (int i = 0; i < 400; i++) begin
            if (i % 37 == 0) begin
                perm_sel = 6'($urandom);
                mode = 2'($urandom);
                threshold = 8'($urandom);
            end
            drive_cycle(24'($urandom), 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 19) == 0), a, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL random_cycle_%0d: got %h expected %h", i, a, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_perm();
        test_gray();
        test_binarize();
        test_zero_cases();
        test_reset_mid_flight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
